nexys4_sevenseg_drv: RTL and testbench

NEXYS4_SEVENSEG_DRV -- requirements
Module: nexys4_sevenseg_drv

---
 rtl/sevenseg_pkg.sv | 14 +
 rtl/sevenseg_decode.sv | 38 +++
 rtl/nexys4_sevenseg_drv.sv | 83 ++++++++
 tb/tb_nexys4_sevenseg_drv.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: character codes, segment width and driver states shared by the display driver and the firmware header
package sevenseg_pkg;
  localparam int SEG_W = 7;
  localparam logic [4:0] CH_H = 5'd16;
  localparam logic [4:0] CH_L = 5'd17;
  localparam logic [4:0] CH_P = 5'd18;
  localparam logic [4:0] CH_R = 5'd19;
  localparam logic [4:0] CH_O = 5'd20;
  localparam logic [4:0] CH_DASH = 5'd21;
  localparam logic [4:0] CH_UNDER = 5'd22;
  localparam logic [4:0] CH_BLANK = 5'd23;
  localparam logic [4:0] CH_LAMP = 5'd31;
  typedef enum logic {SHOW, BLANK} drv_state_t;
endpackage

// File: rtl/sevenseg_decode.sv
// sevenseg_decode: 5-bit character code (code) to active-low {g,f,e,d,c,b,a} segment pattern (seg)
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [4:0]       code,
  output logic [SEG_W-1:0] seg
);
  always_comb begin
    seg = '1;
    case (code)
      5'd0: seg = 7'h40;
      5'd1: seg = 7'h79;
      5'd2: seg = 7'h24;
      5'd3: seg = 7'h30;
      5'd4: seg = 7'h19;
      5'd5: seg = 7'h12;
      5'd6: seg = 7'h02;
      5'd7: seg = 7'h78;
      5'd8: seg = 7'h00;
      5'd9: seg = 7'h10;
      5'd10: seg = 7'h08;
      5'd11: seg = 7'h03;
      5'd12: seg = 7'h46;
      5'd13: seg = 7'h21;
      5'd14: seg = 7'h06;
      5'd15: seg = 7'h0E;
      CH_H: seg = 7'h09;
      CH_L: seg = 7'h47;
      CH_P: seg = 7'h0C;
      CH_R: seg = 7'h2F;
      CH_O: seg = 7'h23;
      CH_DASH: seg = 7'h3F;
      CH_UNDER: seg = 7'h77;
      CH_LAMP: seg = 7'h00;
      default: seg = '1;
    endcase
  end
endmodule

// File: rtl/nexys4_sevenseg_drv.sv
// nexys4_sevenseg_drv: 8-digit multiplexed display driver; dig0..7/dp/digit_en in, active-low an/seg/dp_n and scan_idx out
module nexys4_sevenseg_drv
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       dig0,
  input  logic [4:0]       dig1,
  input  logic [4:0]       dig2,
  input  logic [4:0]       dig3,
  input  logic [4:0]       dig4,
  input  logic [4:0]       dig5,
  input  logic [4:0]       dig6,
  input  logic [4:0]       dig7,
  input  logic [7:0]       dp,
  input  logic [7:0]       digit_en,
  output logic [7:0]       an,
  output logic [SEG_W-1:0] seg,
  output logic             dp_n,
  output logic [2:0]       scan_idx
);
  localparam int CNT_W = $clog2(REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES);
  if (REFRESH_DIV < 2 || BLANK_CYCLES < 1) begin : g_bad_params
    $error("nexys4_sevenseg_drv: REFRESH_DIV must be >= 2 and BLANK_CYCLES >= 1");
  end
  drv_state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0] idx_nx;
  logic [4:0] code_q, code_nx;
  logic dp_q, dp_nx, en_q, en_nx, lit;
  logic [4:0] digs [8];
  logic [7:0] an_nx;
  logic [SEG_W-1:0] seg_dec, seg_nx;
  assign digs = '{dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7};
  always_comb begin
    state_nx = state;
    cnt_nx = cnt + 1'b1;
    idx_nx = scan_idx;
    code_nx = code_q;
    dp_nx = dp_q;
    en_nx = en_q;
    if (state == SHOW && cnt == CNT_W'(REFRESH_DIV - 1)) begin
      state_nx = BLANK;
      cnt_nx = '0;
    end else if (state == BLANK && cnt == CNT_W'(BLANK_CYCLES - 1)) begin
      state_nx = SHOW;
      cnt_nx = '0;
      idx_nx = scan_idx + 1'b1;
      code_nx = digs[idx_nx];
      dp_nx = dp[idx_nx];
      en_nx = digit_en[idx_nx];
    end
  end
  sevenseg_decode u_decode (.code(code_nx), .seg(seg_dec));
  assign lit = state_nx == SHOW && en_nx;
  assign an_nx = lit ? ~(8'd1 << idx_nx) : 8'hFF;
  assign seg_nx = lit ? seg_dec : '1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= BLANK;
      cnt <= '0;
      scan_idx <= 3'd7;
      code_q <= '0;
      dp_q <= 1'b0;
      en_q <= 1'b0;
      an <= 8'hFF;
      seg <= '1;
      dp_n <= 1'b1;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      scan_idx <= idx_nx;
      code_q <= code_nx;
      dp_q <= dp_nx;
      en_q <= en_nx;
      an <= an_nx;
      seg <= seg_nx;
      dp_n <= lit ? ~dp_nx : 1'b1;
    end
endmodule

// File: tb/tb_nexys4_sevenseg_drv.sv
// tb_nexys4_sevenseg_drv: directed self-checking bench for nexys4_sevenseg_drv with REFRESH_DIV=4, BLANK_CYCLES=2
module tb_nexys4_sevenseg_drv;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [4:0] dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7;
  logic [7:0] dp, digit_en, an;
  logic [6:0] seg;
  logic dp_n;
  logic [2:0] scan_idx;
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_idx;
  typedef struct {
    logic [4:0] code;
    logic dpb;
    logic en;
    logic [6:0] seg;
    logic dpn;
  } vec_t;
  vec_t vt [15];
  logic [6:0] hx [8];
  always #5 clk = ~clk;
  nexys4_sevenseg_drv #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .dig4(dig4), .dig5(dig5), .dig6(dig6), .dig7(dig7),
    .dp(dp), .digit_en(digit_en),
    .an(an), .seg(seg), .dp_n(dp_n), .scan_idx(scan_idx)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (slot %0d, t=%0t)", name, act, exp, exp_idx, $time);
    end
  endtask
  task automatic set_all(input logic [4:0] c);
    {dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7} = {8{c}};
  endtask
  task automatic next_slot();
    logic [2:0] want;
    int n;
    want = exp_idx + 3'd1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (scan_idx !== want && n < 14);
    chk("slot_reach", scan_idx, want);
    exp_idx = want;
  endtask
  task automatic check_slot(input logic [6:0] es, input logic edn, input logic en);
    logic [7:0] ea;
    ea = en ? ~(8'd1 << exp_idx) : 8'hFF;
    chk("slot_an", an, ea);
    chk("slot_seg", seg, es);
    chk("slot_dp_n", dp_n, edn);
  endtask
  initial begin
    vt[0] = '{5'd0, 1'b0, 1'b1, 7'h40, 1'b1};
    vt[1] = '{5'd1, 1'b1, 1'b1, 7'h79, 1'b0};
    vt[2] = '{5'd8, 1'b0, 1'b1, 7'h00, 1'b1};
    vt[3] = '{5'd15, 1'b0, 1'b1, 7'h0E, 1'b1};
    vt[4] = '{5'd10, 1'b0, 1'b1, 7'h08, 1'b1};
    vt[5] = '{5'd16, 1'b0, 1'b1, 7'h09, 1'b1};
    vt[6] = '{5'd17, 1'b0, 1'b1, 7'h47, 1'b1};
    vt[7] = '{5'd18, 1'b1, 1'b1, 7'h0C, 1'b0};
    vt[8] = '{5'd19, 1'b0, 1'b1, 7'h2F, 1'b1};
    vt[9] = '{5'd20, 1'b0, 1'b1, 7'h23, 1'b1};
    vt[10] = '{5'd21, 1'b0, 1'b1, 7'h3F, 1'b1};
    vt[11] = '{5'd22, 1'b0, 1'b1, 7'h77, 1'b1};
    vt[12] = '{5'd23, 1'b0, 1'b1, 7'h7F, 1'b1};
    vt[13] = '{5'd31, 1'b1, 1'b1, 7'h00, 1'b0};
    vt[14] = '{5'd30, 1'b1, 1'b0, 7'h7F, 1'b1};
    hx = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    exp_idx = 3'd7;
    {dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0} = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
    dp = 8'h00;
    digit_en = 8'hFF;
    #22;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp_n", dp_n, 1'b1);
    chk("rst_scan_idx", scan_idx, 3'd7);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 56; c++) begin
      logic [2:0] s;
      logic sh;
      logic [7:0] ea;
      if (c > 0) @(negedge clk);
      #1;
      s = 3'd7;
      sh = 1'b0;
      if (c >= 2) begin
        s = 3'(((c - 2) / 6) % 8);
        sh = ((c - 2) % 6) < 4;
      end
      ea = sh ? ~(8'd1 << s) : 8'hFF;
      chk("frame_an", an, ea);
      chk("frame_seg", seg, sh ? hx[s] : 7'h7F);
      chk("frame_scan_idx", scan_idx, s);
      chk("frame_one_hot", 32'($countones(~an) <= 1), 1);
    end
    exp_idx = 3'd0;
    set_all(5'd0);
    while (exp_idx != 3'd7) next_slot();
    next_slot();
    check_slot(7'h40, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    set_all(5'd8);
    @(negedge clk);
    #1;
    chk("hold_seg_c3", seg, 7'h40);
    @(negedge clk);
    #1;
    chk("hold_seg_c4", seg, 7'h40);
    next_slot();
    check_slot(7'h00, 1'b1, 1'b1);
    set_all(5'd5);
    digit_en = 8'hFE;
    for (int i = 0; i < 8; i++) begin
      next_slot();
      check_slot(digit_en[exp_idx] ? 7'h12 : 7'h7F, 1'b1, digit_en[exp_idx]);
    end
    for (int i = 0; i < 15; i++) begin
      set_all(vt[i].code);
      dp = {8{vt[i].dpb}};
      digit_en = {8{vt[i].en}};
      next_slot();
      check_slot(vt[i].seg, vt[i].dpn, vt[i].en);
    end
    set_all(5'd0);
    dig3 = 5'd31;
    dp = 8'h08;
    digit_en = 8'hFF;
    while (exp_idx != 3'd3) next_slot();
    check_slot(7'h00, 1'b0, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_an", an, 8'hFF);
    chk("async_rst_seg", seg, 7'h7F);
    chk("async_rst_dp_n", dp_n, 1'b1);
    chk("async_rst_scan_idx", scan_idx, 3'd7);
    @(posedge clk);
    #1;
    chk("held_rst_an", an, 8'hFF);
    @(negedge clk);
    reset_n = 1'b1;
    exp_idx = 3'd7;
    #1;
    chk("rel_c1_an", an, 8'hFF);
    @(negedge clk);
    #1;
    chk("rel_c2_an", an, 8'hFF);
    @(negedge clk);
    #1;
    exp_idx = 3'd0;
    chk("rel_show_an", an, 8'hFE);
    chk("rel_show_seg", seg, 7'h40);
    chk("rel_show_scan_idx", scan_idx, 3'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
